// File: rtl/duck_move_ctl.sv
// rtl/duck_move_ctl.sv - duck flight/fall/escape motion controller
module duck_move_ctl #(
   parameter int SCREEN_W     = 1024,
   parameter int GROUND_Y     = 640,
   parameter int DUCK_W       = 64,
   parameter int SPEED        = 4,
   parameter int FALL_SPEED   = 8,
   parameter int STEP_DIV     = 650000,
   parameter int FLIGHT_TICKS = 600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_enable,
   input  logic        hunt_start,
   input  logic        duck_hit,
   output logic [11:0] duck_xpos,
   output logic [11:0] duck_ypos,
   output logic        duck_visible,
   output logic        duck_falling,
   output logic        duck_fell,
   output logic        duck_escaped
);

   typedef enum logic [1:0] {IDLE, FLY, FALL, ESCAPE} state_t;

   localparam int DIV_W  = $clog2(STEP_DIV + 1);
   localparam int FC_RAW = $clog2(FLIGHT_TICKS + 1);
   // The direction re-roll looks at the low 6 bits, so keep at least that many.
   localparam int FC_W   = (FC_RAW > 6) ? FC_RAW : 6;

   localparam logic signed [13:0] SPD   = 14'(SPEED);
   localparam logic signed [13:0] FSPD  = 14'(FALL_SPEED);
   localparam logic signed [13:0] X_MAX = 14'(SCREEN_W - DUCK_W);
   localparam logic signed [13:0] Y_MAX = 14'(GROUND_Y);

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [FC_W-1:0]    flight_cnt;
   logic [FC_W-1:0]    flight_nx;
   logic [15:0]        lfsr;
   logic signed [13:0] dx, dy, dy_eff;
   logic signed [13:0] x_sum, y_sum, dx_nx, dy_nx, y_fall, y_esc;
   logic [11:0]        x_nx, y_nx, spawn_x;
   logic               tick;

   always_comb begin
      tick      = (div_cnt == DIV_W'(STEP_DIV - 1));
      flight_nx = flight_cnt + FC_W'(1);
      dy_eff    = dy;
      if (flight_nx[5:0] == 6'd0)
         dy_eff = lfsr[0] ? -SPD : SPD;

      x_sum = signed'({2'b00, duck_xpos}) + dx;
      y_sum = signed'({2'b00, duck_ypos}) + dy_eff;

      x_nx  = x_sum[11:0];
      dx_nx = dx;
      if (x_sum[13]) begin
         x_nx  = '0;
         dx_nx = -dx;
      end else if (x_sum > X_MAX) begin
         x_nx  = X_MAX[11:0];
         dx_nx = -dx;
      end

      y_nx  = y_sum[11:0];
      dy_nx = dy_eff;
      if (y_sum[13]) begin
         y_nx  = '0;
         dy_nx = -dy_eff;
      end else if (y_sum > Y_MAX) begin
         y_nx  = Y_MAX[11:0];
         dy_nx = -dy_eff;
      end

      y_fall = signed'({2'b00, duck_ypos}) + FSPD;
      y_esc  = signed'({2'b00, duck_ypos}) - SPD;

      spawn_x = {2'b00, lfsr[9:0]};
      if (spawn_x > 12'(SCREEN_W - DUCK_W))
         spawn_x = spawn_x - 12'd512;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         duck_xpos    <= '0;
         duck_ypos    <= 12'(GROUND_Y);
         duck_visible <= 1'b0;
         duck_falling <= 1'b0;
         duck_fell    <= 1'b0;
         duck_escaped <= 1'b0;
         dx           <= SPD;
         dy           <= -SPD;
         div_cnt      <= '0;
         flight_cnt   <= '0;
         lfsr         <= 16'hACE1;
      end else begin
         lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);
         duck_fell    <= 1'b0;
         duck_escaped <= 1'b0;

         if (!game_enable) begin
            state        <= IDLE;
            duck_visible <= 1'b0;
            duck_falling <= 1'b0;
         end else begin
            case (state)
               IDLE: if (hunt_start) begin
                  state        <= FLY;
                  duck_xpos    <= spawn_x;
                  duck_ypos    <= 12'(GROUND_Y);
                  dx           <= lfsr[10] ? SPD : -SPD;
                  dy           <= -SPD;
                  flight_cnt   <= '0;
                  div_cnt      <= '0;
                  duck_visible <= 1'b1;
               end
               FLY: if (duck_hit) begin
                  state        <= FALL;
                  duck_falling <= 1'b1;
               end else if (tick) begin
                  duck_xpos  <= x_nx;
                  duck_ypos  <= y_nx;
                  dx         <= dx_nx;
                  dy         <= dy_nx;
                  flight_cnt <= flight_nx;
                  if (flight_nx == FC_W'(FLIGHT_TICKS))
                     state <= ESCAPE;
               end
               FALL: if (tick) begin
                  if (y_fall >= Y_MAX) begin
                     duck_ypos    <= Y_MAX[11:0];
                     duck_fell    <= 1'b1;
                     duck_visible <= 1'b0;
                     duck_falling <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     duck_ypos <= y_fall[11:0];
                  end
               end
               ESCAPE: if (tick) begin
                  if (y_esc[13] || y_esc == '0) begin
                     duck_ypos    <= '0;
                     duck_escaped <= 1'b1;
                     duck_visible <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     duck_ypos <= y_esc[11:0];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
